// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator.
// Produces pixel coordinates, syncs, a visible-region flag, a frame-start strobe
// and a free-running animation-step index for the sprite renderers.
//   vga_clk     pixel clock
//   reset_n     asynchronous active-low reset
//   anim_en     1 = animation index advances on frame starts, 0 = holds
//   DrawX/DrawY current pixel column / line (the raster counters themselves)
//   hs/vs       active-low horizontal / vertical sync
//   blank       1 = visible region, 0 = blanked
//   frame_start one-cycle pulse at pixel (0,0) reached by wrapping
//   anim_frame  animation step index, updated the cycle after frame_start
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned ANIM_BITS       = 2
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  input  logic                 anim_en,
  output logic [9:0]           DrawX,
  output logic [9:0]           DrawY,
  output logic                 hs,
  output logic                 vs,
  output logic                 blank,
  output logic                 frame_start,
  output logic [ANIM_BITS-1:0] anim_frame
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned STEP_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(FRAMES_PER_STEP - 1);

  logic              h_wrap;
  logic              v_wrap;
  logic [CNT_W-1:0]  h_nxt;
  logic [CNT_W-1:0]  v_nxt;
  logic [STEP_W-1:0] step_cnt;

  // Next raster position; the vertical counter only moves on the line wrap.
  always_comb begin
    h_wrap = (DrawX == H_LAST);
    v_wrap = (DrawY == V_LAST);
    h_nxt  = h_wrap ? '0 : DrawX + CNT_W'(1);
    v_nxt  = DrawY;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : DrawY + CNT_W'(1);
    end
  end

  // Raster counters plus decodes taken from the next position, so each decoded
  // flag lines up with the coordinate registered on the same edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= h_nxt;
      DrawY       <= v_nxt;
      hs          <= !((h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END));
      vs          <= !((v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END));
      blank       <= (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
      // Only a genuine wrap counts; the post-reset origin never strobes.
      frame_start <= h_wrap && v_wrap;
    end
  end

  // Animation step: counts enabled frame starts, bumps anim_frame every
  // FRAMES_PER_STEP of them. Updates land the cycle after frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt   <= '0;
      anim_frame <= '0;
    end else if (frame_start && anim_en) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt   <= '0;
        anim_frame <= anim_frame + ANIM_BITS'(1);
      end else begin
        step_cnt   <= step_cnt + STEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen, run with a shrunken raster so many frames fit
// in a short simulation. The reference model derives everything from the
// number of clocks since reset release and the count of enabled frame starts.
module tb_vga_timing_gen;

  localparam int HV = 16, HFP = 2, HS = 3, HBP = 2;
  localparam int VV = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int FPS = 3;
  localparam int AB  = 2;
  localparam int HT    = HV + HFP + HS + HBP;
  localparam int VT    = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          anim_en = 1'b0;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          hs;
  logic          vs;
  logic          blank;
  logic          frame_start;
  logic [AB-1:0] anim_frame;

  int t;       // clocks since reset release
  int en_cnt;  // frame starts seen with anim_en=1 since reset
  int checks;
  int errors;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FRAMES_PER_STEP(FPS), .ANIM_BITS(AB)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .anim_en(anim_en),
    .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank(blank),
    .frame_start(frame_start), .anim_frame(anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference model
  function automatic int ex(int tt);
    return tt % HT;
  endfunction
  function automatic int ey(int tt);
    return (tt / HT) % VT;
  endfunction
  function automatic logic eblank(int tt);
    return (tt != 0) && (ex(tt) < HV) && (ey(tt) < VV);
  endfunction
  function automatic logic ehs(int tt);
    return !((ex(tt) >= HV + HFP) && (ex(tt) < HV + HFP + HS));
  endfunction
  function automatic logic evs(int tt);
    return !((ey(tt) >= VV + VFP) && (ey(tt) < VV + VFP + VS));
  endfunction
  function automatic logic efs(int tt);
    return (tt > 0) && (tt % FRAME == 0);
  endfunction
  function automatic int eanim();
    return (en_cnt / FPS) % (1 << AB);
  endfunction

  // Advance one clock; the model's enabled-frame count follows anim_en as seen
  // by the upcoming edge.
  task automatic tick();
    if (efs(t) && anim_en) en_cnt++;
    @(posedge vga_clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    anim_en = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    checks++; if (DrawX !== 10'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", DrawX); end
    checks++; if (DrawY !== 10'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", DrawY); end
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", vs); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", blank); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
    checks++; if (anim_frame !== AB'(0)) begin errors++; $display("FAIL reset_anim got %0d exp 0", anim_frame); end
    @(negedge vga_clk);
    reset_n = 1'b1;
    t = 0;
    en_cnt = 0;
  endtask

  // Full decode of every output across two frames plus a margin.
  task automatic test_raster();
    int fs_seen;
    fs_seen = 0;
    anim_en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 30; i++) begin
      tick();
      if (frame_start === 1'b1) fs_seen++;
      checks++; if (DrawX !== 10'(ex(t))) begin errors++; $display("FAIL raster_x t=%0d got %0d exp %0d", t, DrawX, ex(t)); end
      checks++; if (DrawY !== 10'(ey(t))) begin errors++; $display("FAIL raster_y t=%0d got %0d exp %0d", t, DrawY, ey(t)); end
      checks++; if (hs !== ehs(t)) begin errors++; $display("FAIL raster_hs t=%0d got %b exp %b", t, hs, ehs(t)); end
      checks++; if (vs !== evs(t)) begin errors++; $display("FAIL raster_vs t=%0d got %b exp %b", t, vs, evs(t)); end
      checks++; if (blank !== eblank(t)) begin errors++; $display("FAIL raster_blank t=%0d got %b exp %b", t, blank, eblank(t)); end
      checks++; if (frame_start !== efs(t)) begin errors++; $display("FAIL raster_fs t=%0d got %b exp %b", t, frame_start, efs(t)); end
      checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL raster_anim t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
    end
    checks++;
    if (fs_seen != 2) begin errors++; $display("FAIL raster_fs_count got %0d exp 2", fs_seen); end
  endtask

  // Continuous enable: index steps every FPS frames and wraps past 3.
  task automatic test_anim_wrap();
    logic wrapped;
    wrapped = 1'b0;
    anim_en = 1'b1;
    for (int i = 0; i < (4 * FPS + 2) * FRAME; i++) begin
      tick();
      if (anim_frame === AB'(0) && en_cnt >= 4 * FPS) wrapped = 1'b1;
      checks++; if (frame_start !== efs(t)) begin errors++; $display("FAIL wrap_fs t=%0d got %b exp %b", t, frame_start, efs(t)); end
      checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL wrap_anim t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
    end
    checks++;
    if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got %b exp 1", wrapped); end
  endtask

  // Hold mid-step for 5 frames, resume, then random per-frame enables.
  task automatic test_anim_hold();
    logic [AB-1:0] held;
    int guard;
    anim_en = 1'b1;
    guard = 0;
    while ((en_cnt % FPS) != 1 && guard < 4 * FPS * FRAME) begin
      tick();
      guard++;
      checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL hold_pre_anim t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
    end
    checks++;
    if ((en_cnt % FPS) != 1) begin errors++; $display("FAIL hold_setup_timeout got %0d exp 1", en_cnt % FPS); end
    tick();
    held = anim_frame;
    anim_en = 1'b0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick();
      checks++; if (anim_frame !== held) begin errors++; $display("FAIL hold_gap t=%0d got %0d exp %0d", t, anim_frame, held); end
    end
    // Step count resumes from 1: the index moves after FPS-1 more enabled frames.
    anim_en = 1'b1;
    for (int i = 0; i < (FPS + 1) * FRAME; i++) begin
      tick();
      checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL hold_resume t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
    end
    for (int f = 0; f < 8; f++) begin
      anim_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < FRAME; i++) begin
        tick();
        checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL hold_rand t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
      end
    end
  endtask

  // Asynchronous reset at a random raster position, then a clean restart.
  task automatic test_reset_mid_frame();
    int pre;
    for (int r = 0; r < 2; r++) begin
      anim_en = 1'b1;
      pre = $urandom_range(FPS * FRAME + 1, (FPS + 1) * FRAME - 1);
      for (int i = 0; i < pre; i++) begin
        tick();
        checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL mid_pre_anim t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
      end
      reset_n = 1'b0;
      #1;
      checks++; if (DrawX !== 10'd0) begin errors++; $display("FAIL mid_rst_x got %0d exp 0", DrawX); end
      checks++; if (DrawY !== 10'd0) begin errors++; $display("FAIL mid_rst_y got %0d exp 0", DrawY); end
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got %b exp 1", hs); end
      checks++; if (vs !== 1'b1) begin errors++; $display("FAIL mid_rst_vs got %b exp 1", vs); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL mid_rst_blank got %b exp 0", blank); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_rst_fs got %b exp 0", frame_start); end
      checks++; if (anim_frame !== AB'(0)) begin errors++; $display("FAIL mid_rst_anim got %0d exp 0", anim_frame); end
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      t = 0;
      en_cnt = 0;
      for (int i = 0; i < FRAME + 2 * HT; i++) begin
        anim_en = 1'($urandom_range(0, 1));
        tick();
        checks++; if (DrawX !== 10'(ex(t))) begin errors++; $display("FAIL post_x t=%0d got %0d exp %0d", t, DrawX, ex(t)); end
        checks++; if (DrawY !== 10'(ey(t))) begin errors++; $display("FAIL post_y t=%0d got %0d exp %0d", t, DrawY, ey(t)); end
        checks++; if (hs !== ehs(t)) begin errors++; $display("FAIL post_hs t=%0d got %b exp %b", t, hs, ehs(t)); end
        checks++; if (vs !== evs(t)) begin errors++; $display("FAIL post_vs t=%0d got %b exp %b", t, vs, evs(t)); end
        checks++; if (blank !== eblank(t)) begin errors++; $display("FAIL post_blank t=%0d got %b exp %b", t, blank, eblank(t)); end
        checks++; if (frame_start !== efs(t)) begin errors++; $display("FAIL post_fs t=%0d got %b exp %b", t, frame_start, efs(t)); end
        checks++; if (anim_frame !== AB'(eanim())) begin errors++; $display("FAIL post_anim t=%0d got %0d exp %0d", t, anim_frame, eanim()); end
      end
    end
  endtask

  initial begin
    t = 0;
    en_cnt = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_raster();
    test_anim_wrap();
    test_anim_hold();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
